// File: rtl/xyolo_databus_responder_pkg.sv
// Shared definitions for the xyolo databus responder.
//   state_e      : responder FSM states (IDLE, WAIT, RESP)
//   DEF_*        : default line and address widths shared with the initiators
//   line_off()   : number of byte-offset bits inside one databus line
package xyolo_databus_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int DEF_DATABUS_W = 256;
  localparam int DEF_IO_ADDR_W = 32;

  // Byte-offset bits of a line; the line index starts right above them.
  function automatic int line_off(input int databus_w);
    return $clog2(databus_w / 8);
  endfunction

endpackage

// File: rtl/xyolo_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i        : per-port request vector
//   last_grant_i : index of the most recently served port
//   gnt_oh_o     : one-hot grant
//   gnt_idx_o    : encoded grant index
//   gnt_valid_o  : at least one port is requesting
module xyolo_rr_arbiter #(
  parameter int N_PORTS = 2,
  parameter int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [N_PORTS-1:0] gnt_oh_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Search upward from last_grant+1, wrapping, and keep the first hit.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    gnt_oh_o    = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int i = 1; i <= N_PORTS; i++) begin
      cand     = (int'(last_grant_i) + i) % N_PORTS;
      cand_idx = IDX_W'(cand);
      if (!gnt_valid_o && req_i[cand_idx]) begin
        gnt_valid_o         = 1'b1;
        gnt_oh_o[cand_idx]  = 1'b1;
        gnt_idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/xyolo_databus_responder.sv
// Memory-side responder of the versat valid/ready databus.
//   clk, rst        : clock, synchronous active-low reset
//   lat             : extra wait cycles per transaction, sampled at grant
//   databus_valid   : per-port request (held until ready)
//   databus_addr    : per-port byte address
//   databus_wdata   : per-port write data
//   databus_wstrb   : per-port byte strobes; zero means read
//   databus_ready   : one-cycle completion pulse per transaction
//   databus_rdata   : read data, nonzero only on the granted slice in the ready cycle
//   busy            : FSM is not idle
module xyolo_databus_responder
  import xyolo_databus_responder_pkg::*;
#(
  parameter int N_PORTS     = 2,
  parameter int DATABUS_W   = DEF_DATABUS_W,
  parameter int IO_ADDR_W   = DEF_IO_ADDR_W,
  parameter int LINE_ADDR_W = 10,
  parameter int LAT_W       = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [LAT_W-1:0]               lat,
  input  logic [N_PORTS-1:0]             databus_valid,
  input  logic [N_PORTS*IO_ADDR_W-1:0]   databus_addr,
  input  logic [N_PORTS*DATABUS_W-1:0]   databus_wdata,
  input  logic [N_PORTS*DATABUS_W/8-1:0] databus_wstrb,
  output logic [N_PORTS-1:0]             databus_ready,
  output logic [N_PORTS*DATABUS_W-1:0]   databus_rdata,
  output logic                           busy
);

  localparam int OFF   = line_off(DATABUS_W);
  localparam int NB    = DATABUS_W / 8;
  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  state_e                     state_q;
  logic [IDX_W-1:0]           port_q, last_q;
  logic [LINE_ADDR_W-1:0]     line_q;
  logic [DATABUS_W-1:0]       wdata_q;
  logic [NB-1:0]              wstrb_q;
  logic [LAT_W-1:0]           cnt_q;
  logic [N_PORTS-1:0]         ready_q;
  logic [N_PORTS*DATABUS_W-1:0] rdata_q;

  logic [DATABUS_W-1:0]       mem [0:2**LINE_ADDR_W-1];

  logic [N_PORTS-1:0]         gnt_oh;
  logic [IDX_W-1:0]           gnt_idx;
  logic                       gnt_valid;

  logic [LINE_ADDR_W-1:0]     gnt_line;
  logic [DATABUS_W-1:0]       gnt_wdata;
  logic [NB-1:0]              gnt_wstrb;

  logic                       acc_d;
  logic [IDX_W-1:0]           acc_port_d;
  logic [LINE_ADDR_W-1:0]     acc_line_d;
  logic [DATABUS_W-1:0]       acc_wdata_d;
  logic [NB-1:0]              acc_wstrb_d;

  xyolo_rr_arbiter #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i        (databus_valid),
    .last_grant_i (last_q),
    .gnt_oh_o     (gnt_oh),
    .gnt_idx_o    (gnt_idx),
    .gnt_valid_o  (gnt_valid)
  );

  assign gnt_line  = databus_addr[gnt_idx*IO_ADDR_W + OFF +: LINE_ADDR_W];
  assign gnt_wdata = databus_wdata[gnt_idx*DATABUS_W +: DATABUS_W];
  assign gnt_wstrb = databus_wstrb[gnt_idx*NB +: NB];

  // The edge entering RESP performs the access. With lat=0 that edge is the
  // grant edge itself, so the live granted request is used instead of the
  // latched copy, which is only being captured on that same edge.
  always_comb begin
    acc_d       = ((state_q == S_IDLE) && gnt_valid && (lat == '0)) ||
                  ((state_q == S_WAIT) && (cnt_q == LAT_W'(1)));
    acc_port_d  = (state_q == S_IDLE) ? gnt_idx   : port_q;
    acc_line_d  = (state_q == S_IDLE) ? gnt_line  : line_q;
    acc_wdata_d = (state_q == S_IDLE) ? gnt_wdata : wdata_q;
    acc_wstrb_d = (state_q == S_IDLE) ? gnt_wstrb : wstrb_q;
  end

  // NOTE: the line memory has no reset; its contents survive rst and only the
  // write enable is gated so a commit coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst && acc_d && (|acc_wstrb_d)) begin
      for (int b = 0; b < NB; b++) begin
        if (acc_wstrb_d[b]) mem[acc_line_d][b*8 +: 8] <= acc_wdata_d[b*8 +: 8];
      end
    end
  end

  // NOTE: all sequential state below uses non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      port_q  <= '0;
      last_q  <= IDX_W'(N_PORTS - 1);
      line_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      ready_q <= '0;
      rdata_q <= '0;
    end else begin
      // Ready and rdata are pulses: cleared unless this edge enters RESP.
      ready_q <= '0;
      rdata_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (gnt_valid) begin
            port_q  <= gnt_idx;
            line_q  <= gnt_line;
            wdata_q <= gnt_wdata;
            wstrb_q <= gnt_wstrb;
            cnt_q   <= lat;
            state_q <= (lat != '0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - LAT_W'(1);
          if (cnt_q == LAT_W'(1)) state_q <= S_RESP;
        end
        S_RESP: begin
          last_q  <= port_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (acc_d) begin
        ready_q[acc_port_d] <= 1'b1;
        if (~|acc_wstrb_d) rdata_q[acc_port_d*DATABUS_W +: DATABUS_W] <= mem[acc_line_d];
      end
    end
  end

  assign databus_ready = ready_q;
  assign databus_rdata = rdata_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_xyolo_databus_responder.sv
// Self-checking bench for xyolo_databus_responder (2 ports, 256-bit lines).
// A flat line array models the memory; arbitration is modelled as "next
// requesting port after the last served one"; timing as lat+1 cycles.
module tb_xyolo_databus_responder;

  localparam int NP  = 2;
  localparam int DW  = 256;
  localparam int AW  = 32;
  localparam int LAW = 10;
  localparam int SW  = DW / 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           lat_in;
  logic [NP-1:0]        valid;
  logic [NP*AW-1:0]     addr;
  logic [NP*DW-1:0]     wdata;
  logic [NP*SW-1:0]     wstrb;
  logic [NP-1:0]        ready;
  logic [NP*DW-1:0]     rdata;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mdl [0:(1<<LAW)-1];
  int            model_last;

  always #5 clk = ~clk;

  xyolo_databus_responder dut (
    .clk           (clk),
    .rst           (rst),
    .lat           (lat_in),
    .databus_valid (valid),
    .databus_addr  (addr),
    .databus_wdata (wdata),
    .databus_wstrb (wstrb),
    .databus_ready (ready),
    .databus_rdata (rdata),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int line_of(input logic [AW-1:0] a);
    return int'((a >> 5) & 32'h3FF);
  endfunction

  // One transaction on port p from an idle responder; checks timing,
  // busy duration, ready pulse and read data against the model.
  task automatic txn(input int p, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input logic [SW-1:0] ws, input int l, input string tag);
    int n = 0;
    int nbusy = 0;
    bit seen = 0;
    int ln = line_of(a);
    logic [DW-1:0] exp_line;
    lat_in           = 4'(l);
    addr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = wd;
    wstrb[p*SW +: SW] = ws;
    valid[p]         = 1'b1;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (busy) nbusy++;
      if (ready != '0) seen = 1;
    end
    check({tag, " latency"}, DW'(n), DW'(l + 1));
    check({tag, " busy_cycles"}, DW'(nbusy), DW'(l + 1));
    check({tag, " ready"}, DW'(ready), DW'(1 << p));
    if (ws == '0) begin
      exp_line = mdl[ln];
    end else begin
      exp_line = '0;
      for (int b = 0; b < SW; b++) if (ws[b]) mdl[ln][b*8 +: 8] = wd[b*8 +: 8];
    end
    check({tag, " rdata_own"}, rdata[p*DW +: DW], exp_line);
    check({tag, " rdata_other"}, rdata[(1-p)*DW +: DW], '0);
    model_last = p;
    valid[p]   = 1'b0;
    @(negedge clk);
    check({tag, " ready_single"}, DW'(ready), '0);
    check({tag, " idle"}, DW'(busy), '0);
  endtask

  initial begin
    logic [DW-1:0] pat_a, wd, old5, old6;
    logic [SW-1:0] ws;
    logic [AW-1:0] a;
    int cyc, last_cyc, got, exp_port, pulses;

    rst = 1'b0; valid = '0; addr = '0; wdata = '0; wstrb = '0; lat_in = '0;
    model_last = NP - 1;
    repeat (3) @(negedge clk);
    check("reset ready", DW'(ready), '0);
    check("reset rdata", rdata[DW-1:0], '0);
    check("reset busy", DW'(busy), '0);
    rst = 1'b1;
    @(negedge clk);

    // Preload lines 0..7 with full-line writes.
    for (int i = 0; i < 8; i++) txn(i % 2, AW'(i << 5), {8{$urandom}}, '1, 0, "preload");

    // Single write then read on port 0, lat=0.
    pat_a = {8{32'hA5C3_0F1E}};
    txn(0, 32'h40, pat_a, '1, 0, "wr_a");
    txn(0, 32'h40, '0, '0, 0, "rd_a");
    check("rd_a const", rdata[DW-1:0], '0);  // rdata returns to zero after the pulse
    txn(0, 32'h40, '0, '0, 0, "rd_a2");

    // Byte strobe on line 3.
    txn(1, 32'h60, '0, '1, 0, "bs_clear");
    txn(1, 32'h60, '1, SW'(1), 0, "bs_wr");
    txn(1, 32'h60, '0, '0, 0, "bs_rd");
    check("bs model", mdl[3], DW'(8'hFF));

    // Latency sweep.
    foreach (pat_a[i]) if (i < 4) begin
      int l;
      l = (i == 0) ? 0 : (i == 1) ? 1 : (i == 2) ? 7 : 15;
      txn(i % 2, 32'h20, '0, '0, l, "lat_sweep");
    end

    // Round robin: both ports hold reads, lat=2.
    lat_in = 4'd2;
    addr = {32'h60, 32'h40};
    wstrb = '0;
    valid = 2'b11;
    cyc = 0; last_cyc = 0; got = 0;
    exp_port = (model_last + 1) % NP;
    while (got < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (ready != '0) begin
        check("rr grant", DW'(ready), DW'(1 << exp_port));
        check("rr rdata", rdata[exp_port*DW +: DW], mdl[line_of(addr[exp_port*AW +: AW])]);
        check("rr spacing", DW'(cyc - last_cyc), DW'((got == 0) ? 3 : 4));
        last_cyc = cyc;
        model_last = exp_port;
        exp_port = (exp_port + 1) % NP;
        got++;
      end
    end
    check("rr count", DW'(got), DW'(4));
    valid = '0;
    @(negedge clk);

    // Reset during the third wait cycle of a port 1 write.
    old5 = mdl[5];
    old6 = mdl[6];
    pulses = 0;
    lat_in = 4'd5;
    addr[AW +: AW] = 32'hA0;
    wdata[DW +: DW] = ~old5;
    wstrb[SW +: SW] = '1;
    valid[1] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ready != '0) pulses++;
    end
    rst = 1'b0;
    valid = '0;
    repeat (2) begin
      @(negedge clk);
      if (ready != '0) pulses++;
    end
    check("rst busy", DW'(busy), '0);
    rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (ready != '0) pulses++;
    end
    check("rst no_ready", DW'(pulses), '0);
    model_last = NP - 1;

    // Write whose commit edge coincides with reset.
    lat_in = 4'd0;
    addr[0 +: AW] = 32'hC0;
    wdata[0 +: DW] = ~old6;
    wstrb[0 +: SW] = '1;
    valid[0] = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_commit ready", DW'(ready), '0);
    valid = '0;
    rst = 1'b1;
    @(negedge clk);

    // After reset, simultaneous requests: port 0 first; line 5 unchanged.
    addr = {32'hC0, 32'hA0};
    wstrb = '0;
    valid = 2'b11;
    cyc = 0;
    while (ready == '0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("post_rst grant", DW'(ready), DW'(1));
    check("post_rst line5", rdata[0 +: DW], old5);
    valid = '0;
    model_last = 0;
    @(negedge clk);
    txn(1, 32'hC0, '0, '0, 0, "rst_commit_rd");
    check("rst_commit line6", mdl[6], old6);

    // Upper-address aliasing.
    txn(0, 32'h40, {8{32'h1357_9BDF}}, '1, 0, "alias_wr");
    txn(1, 32'h40 + (32'h1 << (LAW + 5)), '0, '0, 0, "alias_rd");

    // Randomized traffic against the model.
    for (int k = 0; k < 24; k++) begin
      int ln;
      ln = int'($urandom_range(0, 7));
      a  = ($urandom & ~32'h0000_7FE0) | AW'(ln << 5);
      wd = {8{$urandom}};
      ws = ($urandom_range(0, 1) == 1) ? SW'($urandom) : '0;
      txn(int'($urandom_range(0, 1)), a, wd, ws, int'($urandom_range(0, 3)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xyolo_databus_responder.md
Name: xyolo_databus_responder

Overview:
- Responder (memory end) of the versat databus valid/ready protocol that stage address generators such as the vread/vwrite ext_addrgen pairs use as initiators.
- Arbitrates round-robin among N_PORTS initiator ports and serves each granted request from an internal byte-writable line memory.
- Inserts a programmable access latency so benches and FPGA bring-up can stand in for the DDR/interconnect side of a YOLO stage.

Parameters:
- N_PORTS, 2, number of initiator ports on the databus.
- DATABUS_W, 256, line width in bits; must be a power of two and at least 8.
- IO_ADDR_W, 32, byte-address width per port.
- LINE_ADDR_W, 10, log2 of the number of lines in the internal memory.
- LAT_W, 4, width of the latency configuration input.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- lat  in  LAT_W  extra wait cycles per transaction; sampled at grant.
- databus_valid  in  N_PORTS  per-port request.
- databus_addr  in  N_PORTS*IO_ADDR_W  byte addresses; port p occupies slice p.
- databus_wdata  in  N_PORTS*DATABUS_W  write data.
- databus_wstrb  in  N_PORTS*DATABUS_W/8  byte strobes; nonzero means write, zero means read.
- databus_ready  out  N_PORTS  one-cycle completion pulse.
- databus_rdata  out  N_PORTS*DATABUS_W  read data; valid only in the ready cycle.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Protocol: the initiator holds valid, addr, wdata and wstrb until it sees ready=1 for one cycle. The responder raises ready for exactly one cycle per transaction.
- Line index: addr[LINE_ADDR_W+OFF-1:OFF], where OFF=log2(DATABUS_W/8). Low offset bits and upper bits are ignored, so upper-address aliasing is permitted.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - If any valid bit is set, grant the first requesting port searching upward from last_grant+1, modulo N_PORTS.
  - Latch port id, line index, wdata, wstrb and lat.
  - Go to WAIT if latched lat>0, otherwise go directly to RESP.
- WAIT: decrement the counter and go to RESP when it reaches 0.
- Memory access happens on the clock edge that enters RESP, using the latched values.
  - Write: byte-lane masked write.
  - Read: line is registered into the rdata register.
- RESP:
  - Drive ready[g]=1.
  - Drive the rdata slice of port g with the registered line; a write response drives that slice with zero. All other slices are zero.
  - Update last_grant to g and return to IDLE.
- Latency: a request first seen in IDLE at cycle t gets ready at cycle t+lat+1. Sustained throughput is one transaction per lat+2 cycles.
- No grant decision is made in RESP. The next request is arbitrated in the following IDLE cycle.
- Requests asserted while busy wait. Ports with no valid are skipped.
- Valid dropped mid-transaction is a protocol violation: the transaction completes from latched values and ready still pulses.
- lat changes mid-transaction have no effect until the next grant.
- Reset (rst=0 at an edge):
  - FSM goes to IDLE, ready=0, rdata=0, busy=0, last_grant=N_PORTS-1, so port 0 has first priority after reset.
  - A write whose commit edge coincides with reset is not committed.
  - Memory contents are not reset.
- A read of a line never written returns the memory's undefined initial content; the bench preloads.

Decomposition:
- Shared include (xversat.vh style) holds the FSM state encodings, the OFF derivation macro and the default DATABUS_W/IO_ADDR_W values shared with ext_addrgen.
- One natural sub-module: xyolo_rr_arbiter, a combinational round-robin grant from the request vector and last_grant, output as a one-hot plus an encoded index.
- Line memory is instantiated from the existing iob 2p/sp memory family with a byte-write enable.

Test Plan:
- Single write, then read on port 0, lat=0:
  - Write addr 0x40, wdata=pattern A, wstrb all ones; ready at t+1.
  - Read addr 0x40: rdata[port0]=A in the ready cycle; rdata[port1]=0.
- Byte strobe:
  - Line 3 preloaded 0; write wstrb=0x0000_0001 with wdata all 0xFF.
  - Read-back gives 0x...00FF: only byte 0 changed.
- Round-robin:
  - Both ports hold valid continuously, lat=2.
  - Grant order is 0,1,0,1; each ready comes 4 cycles after the previous one; no port is starved.
- Latency sweep: lat=0,1,7,15. Ready arrives exactly lat+1 cycles after the IDLE sample, and busy is high for lat+1 cycles.
- Reset mid-transaction:
  - Port 1 write with lat=5; assert rst=0 on the third wait cycle.
  - No ready pulse; the line keeps its old value; after release a port 0 request is granted first.
- Aliasing: write addr 0x40, then read addr 0x40 + (1<<(LINE_ADDR_W+5)) with DATABUS_W=256; the read returns the same line.
